// File: rtl/fdivsqrt_uotf_seq.sv
// Radix-4 on-the-fly conversion sequencer for the divide/square-root unit:
// owns U/UM/C, steps them with the external converter and hands off the quotient.

package fdivsqrt_uotf_cfg_pkg;
    typedef struct packed {
        int unsigned DIVb;
    } cvw_t;

    localparam cvw_t FDIV_DEFAULT_CFG = '{DIVb: 32'd16};
endpackage

module fdivsqrt_uotf_seq
    import fdivsqrt_uotf_cfg_pkg::*;
#(
    parameter cvw_t P = FDIV_DEFAULT_CFG
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               sqrten,
    input  logic [7:0]         nsteps,
    input  logic               kill,
    input  logic [P.DIVb:0]    UNext,
    input  logic [P.DIVb:0]    UMNext,
    input  logic               wsneg,
    input  logic               ack,
    output logic [P.DIVb+1:0]  C,
    output logic [P.DIVb:0]    U,
    output logic [P.DIVb:0]    UM,
    output logic               busy,
    output logic               done,
    output logic [P.DIVb:0]    Quot
);

    localparam int unsigned DIVB = P.DIVb;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [7:0]         r_cnt;
    logic [DIVB+1:0]    r_c;
    logic [DIVB:0]      r_u;
    logic [DIVB:0]      r_um;

    state_t             w_state_nxt;
    logic [7:0]         w_cnt_nxt;
    logic [DIVB+1:0]    w_c_nxt;
    logic [DIVB:0]      w_u_nxt;
    logic [DIVB:0]      w_um_nxt;

    // Division starts with a weight-1 digit, square root with a weight-1/4 digit.
    logic [DIVB+1:0]    w_c_init;
    logic [DIVB:0]      w_u_init;

    // Initial mask and root select for the operation being started.
    always_comb begin
        w_c_init = {2'b11, {DIVB{1'b0}}};
        w_u_init = {(DIVB+1){1'b0}};
        if (sqrten) begin
            w_c_init = {4'b1111, {(DIVB-2){1'b0}}};
            w_u_init = {1'b1, {DIVB{1'b0}}};
        end else begin
            w_c_init = {2'b11, {DIVB{1'b0}}};
            w_u_init = {(DIVB+1){1'b0}};
        end
    end

    // Next-state and datapath update; everything holds unless explicitly stepped or loaded.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_c_nxt     = r_c;
        w_u_nxt     = r_u;
        w_um_nxt    = r_um;
        if (kill) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_c_nxt  = w_c_init;
                        w_u_nxt  = w_u_init;
                        w_um_nxt = {(DIVB+1){1'b0}};
                        if (nsteps != 8'd0) begin
                            w_cnt_nxt   = nsteps;
                            w_state_nxt = ST_BUSY;
                        end else begin
                            w_cnt_nxt   = 8'd0;
                            w_state_nxt = ST_DONE;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    w_u_nxt   = UNext;
                    w_um_nxt  = UMNext;
                    w_c_nxt   = {r_c[DIVB+1], r_c[DIVB+1], r_c[DIVB+1:2]};
                    w_cnt_nxt = r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_BUSY;
                    end
                end
                ST_DONE: begin
                    // A start coinciding with ack is dropped; it must come again from IDLE.
                    if (ack) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_c     <= {(DIVB+2){1'b0}};
            r_u     <= {(DIVB+1){1'b0}};
            r_um    <= {(DIVB+1){1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_c     <= w_c_nxt;
            r_u     <= w_u_nxt;
            r_um    <= w_um_nxt;
        end
    end

    assign C    = r_c;
    assign U    = r_u;
    assign UM   = r_um;
    assign busy = (r_state == ST_BUSY);
    assign done = (r_state == ST_DONE);
    // A negative final residual means the last digit overshot, so UM is the true result.
    assign Quot = wsneg ? r_um : r_u;

endmodule

// File: tb/tb_fdivsqrt_uotf_seq.sv
// Directed bench for fdivsqrt_uotf_seq (DIVb=16) with an arithmetic radix-4
// on-the-fly converter closing the loop around the sequencer.

module tb_fdivsqrt_uotf_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        sqrten;
    logic [7:0]  nsteps;
    logic        kill;
    logic [16:0] UNext;
    logic [16:0] UMNext;
    logic        wsneg;
    logic        ack;
    logic [17:0] C;
    logic [16:0] U;
    logic [16:0] UM;
    logic        busy;
    logic        done;
    logic [16:0] Quot;

    int n_checks;
    int n_fail;
    int digit;

    logic [16:0] m_low;
    logic [16:0] m_w;

    fdivsqrt_uotf_seq dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .sqrten (sqrten),
        .nsteps (nsteps),
        .kill   (kill),
        .UNext  (UNext),
        .UMNext (UMNext),
        .wsneg  (wsneg),
        .ack    (ack),
        .C      (C),
        .U      (U),
        .UM     (UM),
        .busy   (busy),
        .done   (done),
        .Quot   (Quot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Converter: U holds Q, UM holds Q - w; digit d at weight w updates both.
    always_comb begin
        m_low = C[16:0];
        m_w   = m_low & (~m_low + 17'd1);
        case (digit)
            2:       begin UNext = U + (m_w << 1);         UMNext = U + m_w; end
            1:       begin UNext = U + m_w;                UMNext = U; end
            0:       begin UNext = U;                      UMNext = UM + m_w + (m_w << 1); end
            -1:      begin UNext = UM + m_w + (m_w << 1);  UMNext = UM + (m_w << 1); end
            -2:      begin UNext = UM + (m_w << 1);        UMNext = UM + m_w; end
            default: begin UNext = U;                      UMNext = UM; end
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (C !== 18'h0) begin n_fail++; $display("FAIL reset_c: got %h want 0", C); end
        n_checks++; if (U !== 17'h0 || UM !== 17'h0) begin n_fail++; $display("FAIL reset_u_um: got %h/%h want 0/0", U, UM); end
        reset = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got busy=%b done=%b want 0/0", busy, done); end
    endtask

    task automatic test_div3();
        start = 1'b1; sqrten = 1'b0; nsteps = 8'd3;
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL div3_busy: got %b want 1", busy); end
        n_checks++; if (C !== 18'h30000 || U !== 17'h0 || UM !== 17'h0) begin n_fail++; $display("FAIL div3_init: got C=%h U=%h UM=%h want 30000/0/0", C, U, UM); end
        digit = 1;  tick();
        digit = 2;  tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL div3_early_done: got %b want 0", done); end
        digit = -1; tick();
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL div3_done: got done=%b busy=%b want 1/0", done, busy); end
        n_checks++; if (U !== 17'h17000) begin n_fail++; $display("FAIL div3_u: got %h want 17000", U); end
        n_checks++; if (UM !== 17'h16000) begin n_fail++; $display("FAIL div3_um: got %h want 16000", UM); end
        wsneg = 1'b0; #1;
        n_checks++; if (Quot !== 17'h17000) begin n_fail++; $display("FAIL div3_quot_pos: got %h want 17000", Quot); end
        wsneg = 1'b1; #1;
        n_checks++; if (Quot !== 17'h16000) begin n_fail++; $display("FAIL div3_quot_neg: got %h want 16000", Quot); end
        wsneg = 1'b0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL div3_ack: got done=%b want 0", done); end
    endtask

    task automatic test_sqrt2();
        start = 1'b1; sqrten = 1'b1; nsteps = 8'd2;
        tick();
        start = 1'b0; sqrten = 1'b0;
        n_checks++; if (C !== 18'h3C000 || U !== 17'h10000 || UM !== 17'h0) begin n_fail++; $display("FAIL sqrt_init: got C=%h U=%h UM=%h want 3c000/10000/0", C, U, UM); end
        digit = 1; tick();
        n_checks++; if (U !== 17'h14000 || UM !== 17'h10000) begin n_fail++; $display("FAIL sqrt_step1: got U=%h UM=%h want 14000/10000", U, UM); end
        n_checks++; if (C !== 18'h3F000) begin n_fail++; $display("FAIL sqrt_c1: got %h want 3f000", C); end
        digit = 0; tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL sqrt_done: got %b want 1", done); end
        n_checks++; if (U !== 17'h14000 || UM !== 17'h13000) begin n_fail++; $display("FAIL sqrt_final: got U=%h UM=%h want 14000/13000", U, UM); end
        n_checks++; if (C !== 18'h3FC00) begin n_fail++; $display("FAIL sqrt_c2: got %h want 3fc00", C); end
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic test_nsteps0();
        start = 1'b1; sqrten = 1'b0; nsteps = 8'd0; wsneg = 1'b0;
        tick();
        start = 1'b0;
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_done: got done=%b busy=%b want 1/0", done, busy); end
        n_checks++; if (Quot !== 17'h0 || C !== 18'h30000) begin n_fail++; $display("FAIL zero_vals: got Quot=%h C=%h want 0/30000", Quot, C); end
        ack = 1'b1; tick(); ack = 1'b0;
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_ack: got done=%b busy=%b want 0/0", done, busy); end
    endtask

    task automatic test_kill();
        start = 1'b1; sqrten = 1'b0; nsteps = 8'd5;
        tick();
        start = 1'b0;
        digit = 1; tick();
        kill = 1'b1; digit = 2;
        tick();
        kill = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL kill_idle: got busy=%b done=%b want 0/0", busy, done); end
        n_checks++; if (U !== 17'h10000) begin n_fail++; $display("FAIL kill_hold_u: got %h want 10000", U); end
        start = 1'b1; nsteps = 8'd1;
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1 || U !== 17'h0 || C !== 18'h30000) begin n_fail++; $display("FAIL kill_restart: got busy=%b U=%h C=%h want 1/0/30000", busy, U, C); end
        digit = 1; tick();
        n_checks++; if (done !== 1'b1 || U !== 17'h10000 || UM !== 17'h0) begin n_fail++; $display("FAIL kill_result: got done=%b U=%h UM=%h want 1/10000/0", done, U, UM); end
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic test_handshake();
        start = 1'b1; sqrten = 1'b0; nsteps = 8'd3;
        tick();
        digit = 1; start = 1'b1; nsteps = 8'd1;
        tick();
        start = 1'b0;
        digit = 2;
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL hs_start_in_busy: got busy=%b done=%b want 1/0", busy, done); end
        tick();
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL hs_count_intact: got busy=%b done=%b want 1/0", busy, done); end
        digit = -1; tick();
        n_checks++; if (done !== 1'b1 || U !== 17'h17000) begin n_fail++; $display("FAIL hs_done: got done=%b U=%h want 1/17000", done, U); end
        digit = 2; wsneg = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++; if (done !== 1'b1 || Quot !== 17'h17000) begin n_fail++; $display("FAIL hs_hold[%0d]: got done=%b Quot=%h want 1/17000", i, done, Quot); end
        end
        ack = 1'b1; start = 1'b1; nsteps = 8'd2;
        tick();
        ack = 1'b0; start = 1'b0;
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL hs_ack_start: got done=%b busy=%b want 0/0", done, busy); end
        tick();
        n_checks++; if (busy !== 1'b0 || U !== 17'h17000) begin n_fail++; $display("FAIL hs_no_load: got busy=%b U=%h want 0/17000", busy, U); end
        start = 1'b1; nsteps = 8'd1;
        tick();
        start = 1'b0;
        digit = 1; tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL hs_b2b_first: got done=%b want 1", done); end
        ack = 1'b1; tick(); ack = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hs_b2b_restart: got busy=%b want 1", busy); end
        tick();
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        start = 1'b1; sqrten = 1'b0; nsteps = 8'd5;
        tick();
        start = 1'b0;
        digit = 1; tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (C !== 18'h0 || U !== 17'h0 || UM !== 17'h0 || Quot !== 17'h0) begin n_fail++; $display("FAIL rst_mid_vals: got C=%h U=%h UM=%h Quot=%h want 0", C, U, UM, Quot); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flags: got busy=%b done=%b want 0/0", busy, done); end
        tick();
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stays_idle: got busy=%b done=%b want 0/0", busy, done); end
        start = 1'b1; nsteps = 8'd2;
        tick();
        start = 1'b0;
        digit = -2; tick();
        digit = 1;  tick();
        n_checks++; if (done !== 1'b1 || U !== 17'h04000 || UM !== 17'h0) begin n_fail++; $display("FAIL rst_div_result: got done=%b U=%h UM=%h want 1/04000/0", done, U, UM); end
        n_checks++; if ((U - UM) !== 17'h04000) begin n_fail++; $display("FAIL rst_div_gap: got %h want 04000", U - UM); end
        n_checks++; if (C !== 18'h3F000) begin n_fail++; $display("FAIL rst_div_c: got %h want 3f000", C); end
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        digit    = 0;
        reset    = 1'b1;
        start    = 1'b0;
        sqrten   = 1'b0;
        nsteps   = 8'd0;
        kill     = 1'b0;
        wsneg    = 1'b0;
        ack      = 1'b0;
        test_reset();
        test_div3();
        test_sqrt2();
        test_nsteps0();
        test_kill();
        test_handshake();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
